ab_pattern_driver: RTL
======================

# ab_pattern_driver

Stimulus generator and response checker for the registered two-input logic block (inputs a/b; registered outputs r0 = a&b, r1 = a&b, r2 = ~(a^b)). On a start pulse it drives a/b through all four combinations, holding each for a fixed number of cycles, and optionally repeats the sweep. With the checker compiled in, it compares the block's registered responses against the expected values one cycle later and counts mismatches. It sits beside the logic block in formal and simulation harnesses as the driving end of its a/b interface.

## Interface
- HOLD_CYCLES, 2, cycles each a/b combination is held; legal range ≥1
- REPEAT, 1, number of full 00→01→10→11 sweeps per run; legal range ≥1
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- start  in  1  run request; sampled only in IDLE
- a  out  1  registered stimulus bit (MSB of pattern)
- b  out  1  registered stimulus bit (LSB of pattern)
- busy  out  1  high in DRIVE and FLUSH
- done  out  1  one-cycle pulse at end of run
- r0_in, r1_in, r2_in  in  1 each  registered responses from the logic block
- err  out  1  one-cycle pulse per mismatching response cycle
- err_cnt  out  8  saturating mismatch count

## Operation
- Reset values: a=0, b=0, busy=0, done=0, err=0, err_cnt=0; state IDLE; hold and sweep counters 0; checker valid pipeline cleared.
- FSM states:
  - IDLE: a/b=00. start=1 → DRIVE, pattern 00 loaded, err_cnt cleared.
  - DRIVE: pattern held HOLD_CYCLES cycles, then advances 00→01→10→11. After 11 completes: if sweep<REPEAT-1, wrap to 00 and increment sweep; else → FLUSH with a/b=00.
  - FLUSH: 2 cycles, a/b=00, lets the last response reach the checker. → DONE.
  - DONE: done=1 for one cycle. → IDLE.
- start outside IDLE is ignored, including start in DONE.
- Hold counter width: $clog2(HOLD_CYCLES)+1. Sweep counter width: $clog2(REPEAT)+1.
- Expected response for sampled pattern {a,b}: r0=r1=a&b, r2=~(a^b).
- Checker:
  - Registers {a,b,drive_valid} one edge after the driver updates them.
  - Compares r*_in against the registered expectation on the following cycle.
  - drive_valid is high only for patterns issued in DRIVE, so IDLE and FLUSH patterns are never checked.
- err_cnt saturates at 255, stays at 255, and is cleared only by rst or an accepted start.
- rst mid-run: all state is returned to reset values immediately and asynchronously; no done pulse is produced; pending checks are discarded.

## Timing
- Edge 0 is the edge that samples start=1. a/b show pattern 00 from edge 0.
- Pattern k (0..3) of sweep s appears at edge (s·4+k)·HOLD_CYCLES.
- FLUSH is entered at edge 4·HOLD_CYCLES·REPEAT. done is high in the cycle after edge 4·HOLD_CYCLES·REPEAT+2. busy falls at that same edge.
- The logic block's response to a pattern driven at edge n is valid after edge n+1. The check result for it appears on err after edge n+2.
- The last DRIVE pattern's check therefore completes at or before the DONE cycle.

## Configuration
- AB_DRIVER_CHECK_EN defined: checker instantiated; err and err_cnt behave as above.
- Not defined: r*_in are ignored and no checker logic is generated. err is tied to 0 and err_cnt to 8'd0. Driver and FSM timing are unchanged.

## Structure
- Package ab_drv_pkg holds:
  - the state enum (IDLE, DRIVE, FLUSH, DONE);
  - the 2-bit pattern typedef;
  - the ERR_CNT_MAX constant (255);
  - the expected-response function.
- Sub-module ab_response_checker holds the expectation pipeline, compare, err and err_cnt. It is instantiated only under AB_DRIVER_CHECK_EN.

## Test plan
- HOLD=2, REPEAT=1, start pulse, ideal DUT:
  - a/b over edges 0..7 = 00,00,01,01,10,10,11,11, then 00;
  - done high after edge 10;
  - err never 1, err_cnt=0.
- HOLD=1, REPEAT=3:
  - 12 DRIVE cycles, pattern wraps 11→00 twice;
  - busy high for 14 cycles;
  - done after edge 14.
- Force r2_in=0 for the whole run, HOLD=2, REPEAT=1:
  - err pulses for each 00 and 11 drive cycle;
  - err_cnt=4 at done.
- Force r0_in=~expected on every check with HOLD=100, REPEAT=1:
  - err_cnt reaches 255 and holds;
  - a new start clears it to 0.
- Assert rst in the middle of pattern 10:
  - a/b, busy, err and err_cnt go to 0 immediately;
  - no done pulse;
  - a later start runs normally from 00.
- start pulsed during DRIVE and during DONE:
  - ignored, with no restart;
  - sequence and done timing identical to the single-start run.

Source files
------------

// File: rtl/ab_pattern_driver_pkg.sv
// Shared types for the a/b pattern driver: FSM states, the 2-bit pattern,
// the response bundle and the expected-response function.
package ab_drv_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, FLUSH, DONE} state_t;

   // {a,b}: a is the MSB
   typedef logic [1:0] pat_t;

   typedef struct packed {
      logic r0;
      logic r1;
      logic r2;
   } resp_t;

   localparam logic [7:0] ERR_CNT_MAX = 8'd255;

   // What the registered logic block must return for a given pattern
   function automatic resp_t exp_resp(pat_t p);
      resp_t r;
      r.r0 = p[1] & p[0];
      r.r1 = p[1] & p[0];
      r.r2 = ~(p[1] ^ p[0]);
      return r;
   endfunction

endpackage

// File: rtl/ab_pattern_driver_if.sv
// Bundle between the pattern driver and the logic block / harness.
// master = driver side, slave = logic block / harness side.
interface ab_pattern_driver_if;
   logic       start;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic       r0_in;
   logic       r1_in;
   logic       r2_in;
   logic       err;
   logic [7:0] err_cnt;

   modport master (input start, r0_in, r1_in, r2_in,
                   output a, b, busy, done, err, err_cnt);
   modport slave  (output start, r0_in, r1_in, r2_in,
                   input a, b, busy, done, err, err_cnt);
endinterface

// File: rtl/ab_pattern_driver_checker.sv
// Response checker: registers the issued pattern and its valid bit one edge
// after the driver, compares the block's responses in the following cycle,
// flags mismatches on err and keeps a saturating mismatch count.
module ab_response_checker
   import ab_drv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  pat_t       pat,
   input  logic       vld,
   input  logic       r0_in,
   input  logic       r1_in,
   input  logic       r2_in,
   output logic       err,
   output logic [7:0] err_cnt
);

   resp_t exp_q;
   logic  vld_q;
   logic  mism;

   // Expectation stage lines up with the logic block's own output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q <= '0;
         vld_q <= 1'b0;
      end else begin
         exp_q <= exp_resp(pat);
         vld_q <= vld;
      end
   end

   assign mism = vld_q && ({r0_in, r1_in, r2_in} != exp_q);

   // Register the compare result; count saturates, cleared on accepted start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err     <= 1'b0;
         err_cnt <= '0;
      end else begin
         err <= mism;
         if (clr)
            err_cnt <= '0;
         else if (mism && err_cnt != ERR_CNT_MAX)
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/ab_pattern_driver.sv
// Stimulus generator for the two-input registered logic block: sweeps a/b
// through 00,01,10,11 holding each HOLD_CYCLES cycles, REPEAT times, then
// flushes two cycles and pulses done.
// Optional checker compiled in with `define AB_DRIVER_CHECK_EN.
module ab_pattern_driver
   import ab_drv_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int REPEAT      = 1
) (
   input  logic            clk,
   input  logic            rst,
   ab_pattern_driver_if.master bus
);

   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int SW = $clog2(REPEAT) + 1;
   localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] REPEAT_LAST = SW'(REPEAT - 1);

   state_t        state, state_nx;
   pat_t          pat, pat_nx;
   logic [HW-1:0] hcnt, hcnt_nx;
   logic [SW-1:0] scnt, scnt_nx;
   logic          clr;
   logic          err_w;
   logic [7:0]    cnt_w;

   // State, pattern and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         pat   <= '0;
         hcnt  <= '0;
         scnt  <= '0;
      end else begin
         state <= state_nx;
         pat   <= pat_nx;
         hcnt  <= hcnt_nx;
         scnt  <= scnt_nx;
      end
   end

   // Next state / pattern; hold counter doubles as the flush timer
   always_comb begin
      state_nx = state;
      pat_nx   = pat;
      hcnt_nx  = hcnt;
      scnt_nx  = scnt;
      clr      = 1'b0;
      case (state)
         IDLE: begin
            pat_nx  = '0;
            hcnt_nx = '0;
            scnt_nx = '0;
            if (bus.start) begin
               state_nx = DRIVE;
               clr      = 1'b1;
            end
         end
         DRIVE: begin
            if (hcnt == HOLD_LAST) begin
               hcnt_nx = '0;
               if (pat == 2'b11) begin
                  pat_nx = '0;
                  if (scnt == REPEAT_LAST)
                     state_nx = FLUSH;
                  else
                     scnt_nx = scnt + SW'(1);
               end else begin
                  pat_nx = pat + 2'd1;
               end
            end else begin
               hcnt_nx = hcnt + HW'(1);
            end
         end
         FLUSH: begin
            pat_nx = '0;
            if (hcnt == HW'(1)) begin
               state_nx = DONE;
               hcnt_nx  = '0;
            end else begin
               hcnt_nx = hcnt + HW'(1);
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.a    = pat[1];
   assign bus.b    = pat[0];
   assign bus.busy = (state == DRIVE) || (state == FLUSH);
   assign bus.done = (state == DONE);

`ifdef AB_DRIVER_CHECK_EN
   ab_response_checker u_chk (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .pat     (pat),
      .vld     (state == DRIVE),
      .r0_in   (bus.r0_in),
      .r1_in   (bus.r1_in),
      .r2_in   (bus.r2_in),
      .err     (err_w),
      .err_cnt (cnt_w)
   );
`else
   assign err_w = 1'b0;
   assign cnt_w = 8'd0;
`endif

   assign bus.err     = err_w;
   assign bus.err_cnt = cnt_w;

endmodule
